// File: rtl/aes_rx_block_packer.sv
// Receive staging buffer: packs 32-bit AHB words big-endian into 128-bit
// blocks and queues them in a DEPTH-entry show-ahead FIFO for the AES core.
module aes_rx_block_packer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic [31:0]     word_in,
  input  logic            word_wr,
  input  logic            rcv_deq,
  input  logic            fix_error,
  output logic [127:0]    rcv_fifo_out,
  output logic            rcv_fifo_empty,
  output logic            rcv_fifo_full,
  output logic [AW:0]     block_count,
  output logic [1:0]      word_idx,
  output logic            overflow_err,
  output logic            underflow_err
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [127:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    word_idx_q, word_idx_d;
  logic [95:0]   stage_q, stage_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          empty;
  logic          full;
  logic          blk_done;
  logic          push;
  logic          pop;
  logic [127:0]  blk_data;

  // Next-state for pointers, count, staging register and sticky errors.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    // fix_error discards a concurrent word, so it can never complete a block
    blk_done = word_wr && !fix_error && (word_idx_q == 2'd3);
    pop      = rcv_deq && !empty;
    // a full FIFO still accepts when the head leaves in the same cycle
    push     = blk_done && (!full || rcv_deq);
    blk_data = {stage_q, word_in};

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    stage_d    = stage_q;
    word_idx_d = word_idx_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (fix_error) begin
      stage_d    = '0;
      word_idx_d = '0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
    end else begin
      if (word_wr) begin
        word_idx_d = word_idx_q + 1'b1;
        case (word_idx_q)
          2'd0:    stage_d[95:64] = word_in;
          2'd1:    stage_d[63:32] = word_in;
          2'd2:    stage_d[31:0]  = word_in;
          default: stage_d        = stage_q;
        endcase
      end
      if (blk_done && !push) begin
        ovf_d = 1'b1;
      end
      if (rcv_deq && empty) begin
        unf_d = 1'b1;
      end
    end
  end

  // Control and staging state with asynchronous reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      stage_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      stage_q    <= stage_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Block storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge HCLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= blk_data;
    end
  end

  assign rcv_fifo_out   = empty ? '0 : mem_q[rd_ptr_q];
  assign rcv_fifo_empty = empty;
  assign rcv_fifo_full  = full;
  assign block_count    = count_q;
  assign word_idx       = word_idx_q;
  assign overflow_err   = ovf_q;
  assign underflow_err  = unf_q;

endmodule
